// File: rtl/pipe_ctrl_v2_pkg.sv
// Shared types for the pipeline control unit.
// FSM encoding and flush counter width.
package pipe_ctrl_v2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/pipe_ctrl_v2_if.sv
// Hold/redirect bundle between ex/bus/id and the control unit.
// slave = control unit view, master = environment view.
interface pipe_ctrl_v2_if #(
  parameter int ADDR_W  = 32,
  parameter int N_STAGE = 4
);

  logic                bus_hold_i;
  logic                ex_hold_i;
  logic                id_hold_i;
  logic                jump_req_i;
  logic [ADDR_W-1:0]   jump_addr_i;
  logic                int_req_i;
  logic [ADDR_W-1:0]   int_addr_i;
  logic                int_ack_o;
  logic                jump_flag_o;
  logic [ADDR_W-1:0]   jump_addr_o;
  logic [N_STAGE-1:0]  hold_flag_o;
  logic [N_STAGE-1:0]  flush_o;
  logic                pend_o;
  logic                hold_tmo_o;

  modport slave (
    input  bus_hold_i, ex_hold_i, id_hold_i,
    input  jump_req_i, jump_addr_i,
    input  int_req_i, int_addr_i,
    output int_ack_o, jump_flag_o, jump_addr_o,
    output hold_flag_o, flush_o, pend_o, hold_tmo_o
  );

  modport master (
    output bus_hold_i, ex_hold_i, id_hold_i,
    output jump_req_i, jump_addr_i,
    output int_req_i, int_addr_i,
    input  int_ack_o, jump_flag_o, jump_addr_o,
    input  hold_flag_o, flush_o, pend_o, hold_tmo_o
  );

endinterface

// File: rtl/pipe_ctrl_v2.sv
// Pipeline control: merges hold sources into stage masks,
// sequences jump/interrupt redirects with pend buffer and flush.
module pipe_ctrl_v2
  import pipe_ctrl_v2_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int N_STAGE   = 4,
  parameter int ID_IDX    = 1,
  parameter int EX_IDX    = 2,
  parameter int FLUSH_CYC = 1,
  parameter int HOLD_TMO  = 255
) (
  input  logic           clk,
  input  logic           rst,
  pipe_ctrl_v2_if.slave  bus
);

  localparam int WD_W = (HOLD_TMO > 0) ? $clog2(HOLD_TMO + 1) : 1;

  function automatic logic [N_STAGE-1:0] low_mask(input int idx);
    logic [N_STAGE-1:0] m;
    m = '0;
    for (int i = 0; i < N_STAGE; i++)
      if (i <= idx) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [N_STAGE-1:0] ID_MASK = low_mask(ID_IDX);
  localparam logic [N_STAGE-1:0] EX_MASK = low_mask(EX_IDX);
  localparam logic [CNT_W-1:0]   FL_CNT  = CNT_W'(FLUSH_CYC);
  localparam logic [WD_W-1:0]    WD_MAX  = WD_W'(HOLD_TMO);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  pend_q, pend_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               tmo_q, tmo_d;

  logic               issue;
  logic               ack;
  logic [ADDR_W-1:0]  iaddr;
  logic [N_STAGE-1:0] hold;
  logic               any_hold;

  always_comb begin
    hold = '0;
    if (bus.bus_hold_i) hold = '1;
    if (bus.ex_hold_i)  hold = hold | EX_MASK;
    if (bus.id_hold_i)  hold = hold | ID_MASK;
    any_hold = bus.bus_hold_i | bus.ex_hold_i | bus.id_hold_i;
  end

  always_comb begin
    wd_d  = '0;
    tmo_d = tmo_q;
    if (bus.bus_hold_i)
      wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    if (HOLD_TMO != 0 && wd_d == WD_MAX)
      tmo_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    issue   = 1'b0;
    ack     = 1'b0;
    iaddr   = '0;
    unique case (state_q)
      ST_IDLE, ST_FLUSH: begin
        // count only advances while the bus lets the bubbles move
        if (state_q == ST_FLUSH && !bus.bus_hold_i) begin
          if (cnt_q <= 1) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        if (bus.jump_req_i && !bus.bus_hold_i) begin
          issue   = 1'b1;
          iaddr   = bus.jump_addr_i;
          state_d = ST_FLUSH;
          cnt_d   = FL_CNT;
        end else if (bus.jump_req_i) begin
          pend_d  = bus.jump_addr_i;
          state_d = ST_PEND;
        end else if (state_q == ST_IDLE &&
                     bus.int_req_i && !any_hold) begin
          issue   = 1'b1;
          ack     = 1'b1;
          iaddr   = bus.int_addr_i;
          state_d = ST_FLUSH;
          cnt_d   = FL_CNT;
        end
      end
      ST_PEND: begin
        if (!bus.bus_hold_i) begin
          issue   = 1'b1;
          iaddr   = bus.jump_req_i ? bus.jump_addr_i : pend_q;
          pend_d  = '0;
          state_d = ST_FLUSH;
          cnt_d   = FL_CNT;
        end else if (bus.jump_req_i) begin
          pend_d = bus.jump_addr_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

  // combinational outputs are gated so reset clears them at once
  always_comb begin
    bus.int_ack_o   = 1'b0;
    bus.jump_flag_o = 1'b0;
    bus.jump_addr_o = '0;
    bus.hold_flag_o = '0;
    bus.flush_o     = '0;
    bus.pend_o      = 1'b0;
    bus.hold_tmo_o  = tmo_q;
    if (!rst) begin
      bus.int_ack_o   = ack;
      bus.jump_flag_o = issue;
      bus.jump_addr_o = iaddr;
      bus.hold_flag_o = hold;
      bus.pend_o      = (state_q == ST_PEND);
      if (issue || state_q == ST_FLUSH)
        bus.flush_o = EX_MASK;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Directed bench for pipe_ctrl_v2 (FLUSH_CYC=1, HOLD_TMO=4).
module tb_pipe_ctrl_v2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_v2_if #(.ADDR_W(32), .N_STAGE(4)) vif ();

  pipe_ctrl_v2 #(
    .ADDR_W(32), .N_STAGE(4), .ID_IDX(1), .EX_IDX(2),
    .FLUSH_CYC(1), .HOLD_TMO(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    vif.bus_hold_i  = 1'b0;
    vif.ex_hold_i   = 1'b0;
    vif.id_hold_i   = 1'b0;
    vif.jump_req_i  = 1'b0;
    vif.jump_addr_i = '0;
    vif.int_req_i   = 1'b0;
    vif.int_addr_i  = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    idle_in();
    step(); #1;
    chk("rst_flag",  32'(vif.jump_flag_o), 32'd0);
    chk("rst_addr",  vif.jump_addr_o,      32'd0);
    chk("rst_hold",  32'(vif.hold_flag_o), 32'd0);
    chk("rst_flush", 32'(vif.flush_o),     32'd0);
    chk("rst_pend",  32'(vif.pend_o),      32'd0);
    chk("rst_tmo",   32'(vif.hold_tmo_o),  32'd0);
    rst = 1'b0;

    // 1: direct jump
    step(); vif.jump_req_i = 1; vif.jump_addr_i = 32'h100; #1;
    chk("t1_flag",   32'(vif.jump_flag_o), 32'd1);
    chk("t1_addr",   vif.jump_addr_o,      32'h100);
    chk("t1_flush0", 32'(vif.flush_o),     32'b0111);
    step(); idle_in(); #1;
    chk("t1_flag1",  32'(vif.jump_flag_o), 32'd0);
    chk("t1_flush1", 32'(vif.flush_o),     32'b0111);
    step(); #1;
    chk("t1_flush2", 32'(vif.flush_o),     32'd0);

    // 2: jump during bus hold is buffered
    step(); vif.bus_hold_i = 1; vif.jump_req_i = 1;
    vif.jump_addr_i = 32'h200; #1;
    chk("t2_hold",   32'(vif.hold_flag_o), 32'b1111);
    chk("t2_flag0",  32'(vif.jump_flag_o), 32'd0);
    step(); vif.jump_req_i = 0; vif.jump_addr_i = '0; #1;
    chk("t2_pend1",  32'(vif.pend_o),      32'd1);
    chk("t2_flag1",  32'(vif.jump_flag_o), 32'd0);
    step(); #1;
    chk("t2_pend2",  32'(vif.pend_o),      32'd1);
    step(); vif.bus_hold_i = 0; #1;
    chk("t2_flag3",  32'(vif.jump_flag_o), 32'd1);
    chk("t2_addr3",  vif.jump_addr_o,      32'h200);
    chk("t2_flush3", 32'(vif.flush_o),     32'b0111);
    step(); #1;
    chk("t2_pend4",  32'(vif.pend_o),      32'd0);
    chk("t2_flag4",  32'(vif.jump_flag_o), 32'd0);
    step(); #1;
    chk("t2_tmo",    32'(vif.hold_tmo_o),  32'd0);

    // 3: last pending jump wins, one issue only
    step(); vif.bus_hold_i = 1; vif.jump_req_i = 1;
    vif.jump_addr_i = 32'h250; #1;
    step(); vif.jump_addr_i = 32'h300; #1;
    chk("t3_flag0",  32'(vif.jump_flag_o), 32'd0);
    step(); idle_in(); #1;
    chk("t3_flag",   32'(vif.jump_flag_o), 32'd1);
    chk("t3_addr",   vif.jump_addr_o,      32'h300);
    step(); #1;
    chk("t3_once1",  32'(vif.jump_flag_o), 32'd0);
    step(); #1;
    chk("t3_once2",  32'(vif.jump_flag_o), 32'd0);

    // 4: jump outranks interrupt
    step(); vif.int_req_i = 1; vif.int_addr_i = 32'h80;
    vif.jump_req_i = 1; vif.jump_addr_i = 32'h400; #1;
    chk("t4_addr",   vif.jump_addr_o,      32'h400);
    chk("t4_ack0",   32'(vif.int_ack_o),   32'd0);
    step(); vif.jump_req_i = 0; vif.jump_addr_i = '0; #1;
    chk("t4_ackfl",  32'(vif.int_ack_o),   32'd0);
    step(); #1;
    chk("t4_ack",    32'(vif.int_ack_o),   32'd1);
    chk("t4_iaddr",  vif.jump_addr_o,      32'h80);
    step(); vif.int_req_i = 0; #1;
    chk("t4_ackoff", 32'(vif.int_ack_o),   32'd0);
    step(); #1;

    // 5: partial holds block interrupts
    step(); vif.ex_hold_i = 1; vif.int_req_i = 1;
    vif.int_addr_i = 32'h90; #1;
    chk("t5_exhold", 32'(vif.hold_flag_o), 32'b0111);
    chk("t5_exack",  32'(vif.int_ack_o),   32'd0);
    step(); vif.ex_hold_i = 0; vif.id_hold_i = 1; #1;
    chk("t5_idhold", 32'(vif.hold_flag_o), 32'b0011);
    chk("t5_idack",  32'(vif.int_ack_o),   32'd0);
    step(); idle_in(); #1;
    chk("t5_noflag", 32'(vif.jump_flag_o), 32'd0);

    // 6: watchdog, then reset mid-PEND
    repeat (4) begin
      step(); vif.bus_hold_i = 1; #1;
    end
    chk("t6_tmo_pre", 32'(vif.hold_tmo_o), 32'd0);
    step(); vif.bus_hold_i = 0; #1;
    chk("t6_tmo",    32'(vif.hold_tmo_o),  32'd1);
    step(); #1;
    chk("t6_sticky", 32'(vif.hold_tmo_o),  32'd1);
    step(); vif.bus_hold_i = 1; vif.jump_req_i = 1;
    vif.jump_addr_i = 32'h500; vif.int_req_i = 1; #1;
    step(); #1;
    chk("t6_pend",   32'(vif.pend_o),      32'd1);
    #1 rst = 1'b1; #1;
    chk("t6_rflag",  32'(vif.jump_flag_o), 32'd0);
    chk("t6_rhold",  32'(vif.hold_flag_o), 32'd0);
    chk("t6_rpend",  32'(vif.pend_o),      32'd0);
    chk("t6_rtmo",   32'(vif.hold_tmo_o),  32'd0);
    chk("t6_rack",   32'(vif.int_ack_o),   32'd0);
    step(); idle_in(); rst = 1'b0; #1;
    chk("t6_nopend", 32'(vif.pend_o),      32'd0);
    chk("t6_noiss",  32'(vif.jump_flag_o), 32'd0);
    step(); #1;
    chk("t6_noiss2", 32'(vif.jump_flag_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
